// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_if
//
// One Wishbone point-to-point link (32-bit data, 4 byte selects).
//
//   adr    : address                (master -> slave)
//   dat_wr : write data             (master -> slave)
//   sel    : byte selects           (master -> slave)
//   we     : write enable           (master -> slave)
//   cyc    : bus cycle              (master -> slave)
//   stb    : strobe                 (master -> slave)
//   dat_rd : read data              (slave  -> master)
//   ack    : acknowledge            (slave  -> master)
//   err    : error termination      (slave  -> master)
//   rty    : retry termination      (slave  -> master)
//
// The arbiter takes each CPU/DMA link through the slave modport and drives
// the shared slave link through the master modport.
// ---------------------------------------------------------------------------
interface wb_rr_arbiter_if;
    logic [31:0] adr;
    logic [31:0] dat_wr;
    logic [31:0] dat_rd;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_wr, sel, we, cyc, stb,
        input  dat_rd, ack, err, rty
    );

    modport slave (
        input  adr, dat_wr, sel, we, cyc, stb,
        output dat_rd, ack, err, rty
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//
// Two-master / one-slave Wishbone arbiter. Grants round-robin, holds the
// grant for the whole cyc period of the winner so bursts and RMW sequences
// stay atomic, and routes the slave response only to the granted master.
// A watchdog ends a stalled strobe with err so a hung slave cannot lock out
// the other master.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   m0   : master 0 link (CPU data bus)       - slave modport
//   m1   : master 1 link (DMA / refresh)      - slave modport
//   s    : shared slave link                  - master modport
//   gnt  : one-hot grant, bit N = master N, 2'b00 when idle
//
// Parameter:
//   tmo_width : watchdog width; err fires after 2**tmo_width-1 stalled
//               cycles of the granted strobe.
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int tmo_width = 10
) (
    input  logic             clk,
    input  logic             rst,
    wb_rr_arbiter_if.slave   m0,
    wb_rr_arbiter_if.slave   m1,
    wb_rr_arbiter_if.master  s,
    output logic [1:0]       gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                 state_reg;
    logic                   last_reg;   // index of the most recently granted master
    logic [1:0]             gnt_reg;
    logic [tmo_width-1:0]   cnt_reg;

    logic req0;
    logic req1;
    logic stall;
    logic tmo_hit;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;

    // -----------------------------------------------------------------------
    // Grant FSM. gnt is registered alongside the state so it changes only on
    // a clock edge (or asynchronously on reset).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;      // master 0 wins the first tie
            gnt_reg   <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    // On a tie the master that was not granted last wins.
                    if (req0 && (!req1 || last_reg)) begin
                        state_reg <= GNT0;
                        last_reg  <= 1'b0;
                        gnt_reg   <= 2'b01;
                    end else if (req1) begin
                        state_reg <= GNT1;
                        last_reg  <= 1'b1;
                        gnt_reg   <= 2'b10;
                    end
                end
                GNT0: begin
                    // Hold while cyc is up; on release hand straight over.
                    if (!m0.cyc) begin
                        if (req1) begin
                            state_reg <= GNT1;
                            last_reg  <= 1'b1;
                            gnt_reg   <= 2'b10;
                        end else begin
                            state_reg <= IDLE;
                            gnt_reg   <= 2'b00;
                        end
                    end
                end
                GNT1: begin
                    if (!m1.cyc) begin
                        if (req0) begin
                            state_reg <= GNT0;
                            last_reg  <= 1'b0;
                            gnt_reg   <= 2'b01;
                        end else begin
                            state_reg <= IDLE;
                            gnt_reg   <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt = gnt_reg;

    // -----------------------------------------------------------------------
    // Slave-side mux, purely from the state so it drops to zero the moment
    // reset asserts. Slave cyc follows the owner, which leaves a one-cycle
    // gap at every handover.
    // -----------------------------------------------------------------------
    always_comb begin
        s.adr    = 32'h0;
        s.dat_wr = 32'h0;
        s.sel    = 4'h0;
        s.we     = 1'b0;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        case (state_reg)
            GNT0: begin
                s.adr    = m0.adr;
                s.dat_wr = m0.dat_wr;
                s.sel    = m0.sel;
                s.we     = m0.we;
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
            end
            GNT1: begin
                s.adr    = m1.adr;
                s.dat_wr = m1.dat_wr;
                s.sel    = m1.sel;
                s.we     = m1.we;
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Watchdog. Counts cycles of an unterminated strobe; at all-ones it
    // raises a one-cycle err. A real ack in the same cycle wins over the
    // timeout, and the count restarts after the timeout fires.
    // -----------------------------------------------------------------------
    assign stall   = (state_reg != IDLE) & s.stb & ~s.ack & ~s.err & ~s.rty;
    assign tmo_hit = (&cnt_reg) & s.stb & ~s.ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (stall && !tmo_hit) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
            cnt_reg <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Response routing: only the granted master sees terminations; read
    // data is broadcast since it is meaningless without ack.
    // -----------------------------------------------------------------------
    assign m0.dat_rd = s.dat_rd;
    assign m1.dat_rd = s.dat_rd;

    assign m0.ack = (state_reg == GNT0) & s.ack;
    assign m0.err = (state_reg == GNT0) & (s.err | tmo_hit);
    assign m0.rty = (state_reg == GNT0) & s.rty;

    assign m1.ack = (state_reg == GNT1) & s.ack;
    assign m1.err = (state_reg == GNT1) & (s.err | tmo_hit);
    assign m1.rty = (state_reg == GNT1) & s.rty;

endmodule
